// File: rtl/mem_stage_pkg.sv
// Shared definitions for the pipeline MEM stage.
//   - Bit positions of the 4-bit control word carried in the EX/MEM register.
//   - State encoding of the memory-access FSM.
package mem_stage_pkg;

  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage.
// Non-memory ops flow straight to the registered write-back outputs with a
// latency of one cycle. Loads and stores run a req/ack access against a
// multi-cycle data memory while the stage holds the upstream pipeline.
//
// Ports:
//   clk_i, rst_n_i             clock, asynchronous active-low reset
//   control_i[3:0]             RegWrite, MemtoReg, MemRead, MemWrite
//   ALUResult_i, RSdata2_i     ALU result / byte address, store data
//   RDaddr_i                   destination register
//   stall_o                    combinational hold request to upstream
//   mem_req_o, mem_we_o        registered memory request and direction
//   mem_addr_o, mem_wdata_o    registered address and store data
//   mem_ack_i, mem_rdata_i     completion strobe and load data
//   wb_we_o, wb_addr_o,        registered write-back bundle
//   wb_data_o
//   misalign_o, bus_error_o    one-cycle error pulses
//   dbg_state_o                current FSM state (0=IDLE, 1=ACCESS)
//
// Memory handshake: mem_req_o stays high, with mem_we_o/mem_addr_o/
// mem_wdata_o held stable, from the first ACCESS cycle until the cycle in
// which mem_ack_i is seen high (the transfer completes on that edge, and
// mem_rdata_i is sampled there) or the timeout aborts the access. mem_ack_i
// is a single-cycle strobe and is ignored whenever mem_req_o is low.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  control_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] RSdata2_i,
  input  logic [4:0]  RDaddr_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_we_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o,
  output logic        bus_error_o,
  output logic        dbg_state_o
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  // Registered state
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_req;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [4:0]    r_rd;
  logic          r_regwrite;
  logic          r_memtoreg;
  logic          r_wb_we;
  logic [4:0]    r_wb_addr;
  logic [31:0]   r_wb_data;
  logic          r_misalign;
  logic          r_bus_err;

  // Next-state values
  state_t        w_state_nx;
  logic [CW-1:0] w_cnt_nx;
  logic          w_req_nx;
  logic          w_we_nx;
  logic [31:0]   w_addr_nx;
  logic [31:0]   w_wdata_nx;
  logic [4:0]    w_rd_nx;
  logic          w_regwrite_nx;
  logic          w_memtoreg_nx;
  logic          w_wb_we_nx;
  logic [4:0]    w_wb_addr_nx;
  logic [31:0]   w_wb_data_nx;
  logic          w_misalign_nx;
  logic          w_bus_err_nx;
  logic          w_stall;

  logic          w_mem_op;
  logic          w_aligned;
  logic          w_last;

  assign w_mem_op  = control_i[CTRL_MEMREAD] | control_i[CTRL_MEMWRITE];
  assign w_aligned = (ALUResult_i[1:0] == 2'b00);
  assign w_last    = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_req_nx      = r_req;
    w_we_nx       = r_we;
    w_addr_nx     = r_addr;
    w_wdata_nx    = r_wdata;
    w_rd_nx       = r_rd;
    w_regwrite_nx = r_regwrite;
    w_memtoreg_nx = r_memtoreg;
    w_wb_we_nx    = 1'b0;  // bubble unless an instruction retires this edge
    w_wb_addr_nx  = r_wb_addr;
    w_wb_data_nx  = r_wb_data;
    w_misalign_nx = 1'b0;
    w_bus_err_nx  = 1'b0;
    w_stall       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (!w_mem_op) begin
          w_wb_we_nx   = control_i[CTRL_REGWRITE];
          w_wb_addr_nx = RDaddr_i;
          w_wb_data_nx = ALUResult_i;
        end else if (!w_aligned) begin
          // Misaligned access is dropped; upstream is allowed to advance.
          w_misalign_nx = 1'b1;
        end else begin
          w_stall       = 1'b1;
          w_req_nx      = 1'b1;
          // MemWrite wins when both MemRead and MemWrite are set.
          w_we_nx       = control_i[CTRL_MEMWRITE];
          w_addr_nx     = ALUResult_i;
          w_wdata_nx    = RSdata2_i;
          w_rd_nx       = RDaddr_i;
          w_regwrite_nx = control_i[CTRL_REGWRITE];
          w_memtoreg_nx = control_i[CTRL_MEMTOREG];
          w_cnt_nx      = '0;
          w_state_nx    = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // Ack is checked first so that an ack in the final cycle completes
        // normally rather than raising a bus error.
        if (mem_ack_i) begin
          w_req_nx     = 1'b0;
          w_state_nx   = ST_IDLE;
          w_wb_addr_nx = r_rd;
          if (!r_we) begin
            w_wb_we_nx   = r_regwrite;
            w_wb_data_nx = r_memtoreg ? mem_rdata_i : r_addr;
          end
        end else if (w_last) begin
          w_req_nx     = 1'b0;
          w_bus_err_nx = 1'b1;
          w_state_nx   = ST_IDLE;
        end else begin
          w_stall  = 1'b1;
          w_cnt_nx = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_req      <= w_req_nx;
      r_we       <= w_we_nx;
      r_addr     <= w_addr_nx;
      r_wdata    <= w_wdata_nx;
      r_rd       <= w_rd_nx;
      r_regwrite <= w_regwrite_nx;
      r_memtoreg <= w_memtoreg_nx;
      r_wb_we    <= w_wb_we_nx;
      r_wb_addr  <= w_wb_addr_nx;
      r_wb_data  <= w_wb_data_nx;
      r_misalign <= w_misalign_nx;
      r_bus_err  <= w_bus_err_nx;
    end
  end

  // Stall is combinational from the inputs; gating with reset keeps it low
  // while the stage is held in reset even if a memory op sits upstream.
  assign stall_o     = rst_n_i & w_stall;
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign wb_we_o     = r_wb_we;
  assign wb_addr_o   = r_wb_addr;
  assign wb_data_o   = r_wb_data;
  assign misalign_o  = r_misalign;
  assign bus_error_o = r_bus_err;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage (TIMEOUT=4).
// Inputs change and outputs are checked on the falling clock edge; the
// DUT updates on the rising edge.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic [3:0]  control;
  logic [31:0] alu_result;
  logic [31:0] rs_data2;
  logic [4:0]  rd_addr;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_error;
  logic        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .control_i   (control),
    .ALUResult_i (alu_result),
    .RSdata2_i   (rs_data2),
    .RDaddr_i    (rd_addr),
    .stall_o     (stall),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata),
    .wb_we_o     (wb_we),
    .wb_addr_o   (wb_addr),
    .wb_data_o   (wb_data),
    .misalign_o  (misalign),
    .bus_error_o (bus_error),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] r);
    control    = c;
    alu_result = a;
    rs_data2   = d;
    rd_addr    = r;
  endtask

  int stall_cnt;

  initial begin
    rst_n     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    drive(4'b0000, 32'h0, 32'h0, 5'd0);

    // Reset state
    step();
    #1;
    chk("rst_mem_req",  mem_req,   0);
    chk("rst_wb_we",    wb_we,     0);
    chk("rst_wb_data",  wb_data,   0);
    chk("rst_stall",    stall,     0);
    chk("rst_misalign", misalign,  0);
    chk("rst_bus_err",  bus_error, 0);
    chk("rst_state",    dbg_state, 0);
    rst_n = 1'b1;
    step();

    // ALU op: result appears one cycle later, no stall
    drive(4'b1000, 32'h0000_00A5, 32'h0, 5'd7);
    #1 chk("alu_stall", stall, 0);
    step();
    chk("alu_wb_we",   wb_we,   1);
    chk("alu_wb_addr", wb_addr, 7);
    chk("alu_wb_data", wb_data, 32'hA5);
    chk("alu_mem_req", mem_req, 0);
    drive(4'b0000, 32'h0, 32'h0, 5'd0);
    step();
    chk("nop_wb_we", wb_we, 0);

    // Load, ack in third ACCESS cycle: occupies 4 cycles, stall high in 3
    drive(4'b1110, 32'h100, 32'h0, 5'd9);
    stall_cnt = 0;
    #1 if (stall) stall_cnt++;
    step();
    chk("ld_mem_req",  mem_req,   1);
    chk("ld_mem_we",   mem_we,    0);
    chk("ld_mem_addr", mem_addr,  32'h100);
    chk("ld_state",    dbg_state, 1);
    chk("ld_bubble",   wb_we,     0);
    #1 if (stall) stall_cnt++;
    step();
    chk("ld_req_hold", mem_req, 1);
    #1 if (stall) stall_cnt++;
    step();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1 if (stall) stall_cnt++;
    chk("ld_stall_cycles", stall_cnt, 3);
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    drive(4'b0000, 32'h0, 32'h0, 5'd0);
    chk("ld_wb_we",    wb_we,     1);
    chk("ld_wb_addr",  wb_addr,   9);
    chk("ld_wb_data",  wb_data,   32'hDEAD_BEEF);
    chk("ld_req_drop", mem_req,   0);
    chk("ld_idle",     dbg_state, 0);
    step();

    // Store with immediate ack
    drive(4'b0001, 32'h200, 32'h1234, 5'd3);
    #1 chk("st_stall_idle", stall, 1);
    step();
    chk("st_mem_req",   mem_req,   1);
    chk("st_mem_we",    mem_we,    1);
    chk("st_mem_addr",  mem_addr,  32'h200);
    chk("st_mem_wdata", mem_wdata, 32'h1234);
    mem_ack = 1'b1;
    #1 chk("st_stall_ack", stall, 0);
    step();
    mem_ack = 1'b0;
    drive(4'b0000, 32'h0, 32'h0, 5'd0);
    chk("st_wb_we",    wb_we,   0);
    chk("st_wb_addr",  wb_addr, 3);
    chk("st_req_drop", mem_req, 0);
    step();

    // Misaligned load
    drive(4'b1110, 32'h102, 32'h0, 5'd4);
    #1 chk("mis_stall", stall, 0);
    step();
    drive(4'b0000, 32'h0, 32'h0, 5'd0);
    chk("mis_pulse",   misalign, 1);
    chk("mis_mem_req", mem_req,  0);
    chk("mis_wb_we",   wb_we,    0);
    step();
    chk("mis_pulse_end", misalign, 0);
    chk("mis_no_req",    mem_req,  0);

    // Timeout with no ack: request held 4 cycles then bus error
    drive(4'b1110, 32'h300, 32'h0, 5'd5);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req_%0d", i), mem_req, 1);
      chk($sformatf("to_berr_%0d", i), bus_error, 0);
      #1 chk($sformatf("to_stall_%0d", i), stall, (i < 3) ? 1 : 0);
      step();
    end
    drive(4'b0000, 32'h0, 32'h0, 5'd0);
    chk("to_req_drop", mem_req,   0);
    chk("to_berr",     bus_error, 1);
    chk("to_state",    dbg_state, 0);
    chk("to_wb_we",    wb_we,     0);
    chk("to_no_mis",   misalign,  0);
    step();
    chk("to_berr_end", bus_error, 0);

    // Ack in the final cycle wins over timeout
    drive(4'b1110, 32'h304, 32'h0, 5'd6);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("la_req_%0d", i), mem_req, 1);
      if (i == 3) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
      end
      step();
    end
    mem_ack   = 1'b0;
    mem_rdata = '0;
    drive(4'b0000, 32'h0, 32'h0, 5'd0);
    chk("la_no_berr", bus_error, 0);
    chk("la_wb_we",   wb_we,     1);
    chk("la_wb_addr", wb_addr,   6);
    chk("la_wb_data", wb_data,   32'hCAFE_F00D);
    chk("la_req",     mem_req,   0);
    step();

    // Reset in the middle of an access
    drive(4'b1110, 32'h400, 32'h0, 5'd6);
    step();
    chk("mr_req_before", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_req",   mem_req,   0);
    chk("mr_stall", stall,     0);
    chk("mr_wb_we", wb_we,     0);
    chk("mr_state", dbg_state, 0);
    step();
    drive(4'b1000, 32'h55, 32'h0, 5'd8);
    rst_n = 1'b1;
    step();
    chk("mr_alu_wb_we",   wb_we,   1);
    chk("mr_alu_wb_addr", wb_addr, 8);
    chk("mr_alu_wb_data", wb_data, 32'h55);
    chk("mr_alu_req",     mem_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
